// File: rtl/cla_sum_stage.sv
// cla_sum_stage: sum/flag stage that follows the carry-lookahead network.
// It forms the sum, carry-out, signed-overflow and zero flags from the
// per-bit propagate and carry-in vectors. The results leave through a
// valid/ready interface. A 2-entry skid buffer (OUT + SKD) allows full
// throughput while ready_o comes straight from the state register.
module cla_sum_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic             cout_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int NGRP = WIDTH / 4;
    // Stored result layout: {zero, ovf, cout, sum}.
    localparam int RW   = WIDTH + 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   out_q, out_d;
    logic [RW-1:0]   skd_q, skd_d;

    logic [WIDTH-1:0] sum_w;
    logic [NGRP-1:0]  grp_zero;
    logic [RW-1:0]    result;
    logic             in_xfer;
    logic             out_xfer;

    // Each 4-bit group matches one lookahead group. The sum is formed
    // per group, and each group reports whether its nibble is zero.
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        assign sum_w[4*gi +: 4] = p_i[4*gi +: 4] ^ c_i[4*gi +: 4];
        assign grp_zero[gi]     = ~|sum_w[4*gi +: 4];
    end

    // Overflow: carry into the sign bit differs from carry out of it.
    assign result = {&grp_zero, c_i[WIDTH-1] ^ cout_i, cout_i, sum_w};

    // Handshake flags are decoded from the state register only.
    assign ready_o  = (state_q != TWO);
    assign valid_o  = (state_q != EMPTY);
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    assign sum_o  = out_q[WIDTH-1:0];
    assign cout_o = out_q[WIDTH];
    assign ovf_o  = out_q[WIDTH+1];
    assign zero_o = out_q[WIDTH+2];

    // Next-state and storage update for the two-entry skid buffer.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skd_d   = skd_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    out_d   = result;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    out_d = result;
                end else if (in_xfer) begin
                    // Downstream is stalled, so OUT keeps its value and the new result goes to SKD.
                    state_d = TWO;
                    skd_d   = result;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // ready_o is low here, so only the drain can happen.
                if (out_xfer) begin
                    state_d = ONE;
                    out_d   = skd_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and storage registers; reset discards any held results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skd_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skd_q   <= skd_d;
        end
    end

endmodule

// File: tb/tb_cla_sum_stage.sv
// tb_cla_sum_stage: directed bench for cla_sum_stage (WIDTH=64).
// Operands a/b/cin are turned into p/c vectors with a ripple-carry
// model of the upstream network. Expected results come from a+b+cin.
`timescale 1ns/1ps
module tb_cla_sum_stage;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] p_i;
    logic [W-1:0] c_i;
    logic         cout_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;
    logic         zero_o;

    int checks_cnt;
    int fail_cnt;

    cla_sum_stage #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .p_i     (p_i),
        .c_i     (c_i),
        .cout_i  (cout_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o),
        .zero_o  (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one value and prints one line for each comparison.
    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s val=%0h", tag, got);
        end
    endtask

    // Upstream model: ripple carry gives c_i and cout_i from a, b and cin.
    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic c;
        c = cin;
        for (int i = 0; i < W; i++) begin
            c_i[i] = c;
            c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
        end
        p_i    = a ^ b;
        cout_i = c;
    endtask

    // Reference result {zero, ovf, cout, sum} from the integer sum.
    function automatic logic [W+2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] s;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {(s[W-1:0] == '0), ovf, s[W], s[W-1:0]};
    endfunction

    function automatic logic [W+2:0] dut_res();
        return {zero_o, ovf_o, cout_o, sum_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] va [0:15];
    logic [W-1:0] vb [0:15];
    logic         vc [0:15];
    logic [W-1:0] ra [0:2];
    logic [W-1:0] rb [0:2];

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        p_i     = '0;
        c_i     = '0;
        cout_i  = 1'b0;

        // Reset state
        #12;
        check_val("rst_valid", valid_o, 0);
        check_val("rst_ready", ready_o, 1);
        check_val("rst_res", dut_res(), 0);
        rst = 1'b0;
        @(negedge clk);

        // Wrap to zero
        set_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        check_val("wrap_p", p_i, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("wrap_c", {cout_i, c_i}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        valid_i = 1'b1;
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        check_val("wrap_valid", valid_o, 1);
        check_val("wrap_res", dut_res(), {1'b1, 1'b0, 1'b1, 64'h0});
        step();
        check_val("wrap_drain", valid_o, 0);

        // Signed overflow
        set_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        check_val("ovf_valid", valid_o, 1);
        check_val("ovf_res", dut_res(), {1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000});
        step();

        // Backpressure and skid: R0, R1, R2 are offered while ready_i=0.
        ra[0] = 64'h0000_0000_0000_0010; rb[0] = 64'h0000_0000_0000_0005;
        ra[1] = 64'h1234_5678_9ABC_DEF0; rb[1] = 64'h1111_1111_1111_1111;
        ra[2] = 64'h8000_0000_0000_0000; rb[2] = 64'h8000_0000_0000_0000;
        ready_i = 1'b0;
        set_op(ra[0], rb[0], 1'b0);
        valid_i = 1'b1;
        step();
        check_val("skid_r0_ready", ready_o, 1);
        set_op(ra[1], rb[1], 1'b1);
        step();
        check_val("skid_full_ready", ready_o, 0);
        check_val("skid_r0_hold", dut_res(), ref_res(ra[0], rb[0], 1'b0));
        set_op(ra[2], rb[2], 1'b0);
        step();
        check_val("skid_stall_ready", ready_o, 0);
        check_val("skid_stall_valid", valid_o, 1);
        check_val("skid_r0_stable", dut_res(), ref_res(ra[0], rb[0], 1'b0));
        ready_i = 1'b1;
        step();
        check_val("skid_out_r1", dut_res(), ref_res(ra[1], rb[1], 1'b1));
        check_val("skid_ready_back", ready_o, 1);
        step();
        valid_i = 1'b0;
        check_val("skid_out_r2", dut_res(), ref_res(ra[2], rb[2], 1'b0));
        step();
        check_val("skid_empty", valid_o, 0);

        // Streaming with a new random vector every cycle
        for (int i = 0; i < 16; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
            vc[i] = 1'($urandom_range(0, 1));
        end
        set_op(va[0], vb[0], vc[0]);
        valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check_val($sformatf("stream%0d_valid", i), valid_o, 1);
            check_val($sformatf("stream%0d_ready", i), ready_o, 1);
            check_val($sformatf("stream%0d_res", i), dut_res(), ref_res(va[i], vb[i], vc[i]));
            if (i < 15) set_op(va[i+1], vb[i+1], vc[i+1]);
            else valid_i = 1'b0;
        end
        step();

        // Asynchronous reset while in TWO
        ready_i = 1'b0;
        set_op(64'h5, 64'h6, 1'b0);
        valid_i = 1'b1;
        step();
        step();
        check_val("rstmid_in_two", ready_o, 0);
        valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("rstmid_valid", valid_o, 0);
        check_val("rstmid_ready", ready_o, 1);
        check_val("rstmid_res", dut_res(), 0);
        rst = 1'b0;
        set_op(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        valid_i = 1'b1;
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        check_val("rstmid_next_valid", valid_o, 1);
        check_val("rstmid_next_res", dut_res(), {1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0000});
        step();
        check_val("rstmid_discarded", valid_o, 0);

        // Idle with random input values and valid_i low
        for (int i = 0; i < 10; i++) begin
            p_i    = {$urandom, $urandom};
            c_i    = {$urandom, $urandom};
            cout_i = 1'($urandom_range(0, 1));
            step();
            check_val($sformatf("idle%0d_valid", i), valid_o, 0);
            check_val($sformatf("idle%0d_ready", i), ready_o, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
